// File: rtl/rgb_led_pkg.sv
// Shared types and constants for the RGB LED arbiter slice.
package rgb_led_pkg;

  localparam int PWM_BITS = 8;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } color_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } arb_state_t;

endpackage

// File: rtl/rgb_led_arbiter_if.sv
// Request/colour/grant bundle between the effect generators and the arbiter.
// Colours are packed {r,g,b} per requester, requester i at bits [24i+23:24i].
interface rgb_led_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import rgb_led_pkg::*;

  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ*24-1:0] color;
  logic [NUM_REQ-1:0]    grant;

  modport master (
    output req,
    output color,
    input  grant
  );

  modport slave (
    input  req,
    input  color,
    output grant
  );

endinterface

// File: rtl/rgb_pwm.sv
// Three-channel 8-bit PWM. Duties are taken from the shadow colour only at the
// end of a PWM period so a colour change never produces a partial period.
module rgb_pwm
  import rgb_led_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  color_t shadow,
  output logic   pwm_r,
  output logic   pwm_g,
  output logic   pwm_b
);

  logic [PWM_BITS-1:0] pwm_cnt;
  color_t              active;

  // Free-running period counter; latch the new duties on the last count of a period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt <= '0;
      active  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (pwm_cnt == '1) begin
        active <= shadow;
      end
    end
  end

  // Registered comparators keep the pins glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_r <= 1'b0;
      pwm_g <= 1'b0;
      pwm_b <= 1'b0;
    end else begin
      pwm_r <= (pwm_cnt < active.r);
      pwm_g <= (pwm_cnt < active.g);
      pwm_b <= (pwm_cnt < active.b);
    end
  end

endmodule

// File: rtl/rgb_led_arbiter.sv
// Round-robin owner of the single RGB LED. Each owner keeps the LED for at
// least SLICE_CYCLES before a waiting requester can take it, and every handover
// passes through one dark GAP cycle so two effects never mix on the pins.
module rgb_led_arbiter
  import rgb_led_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int CLK_FREQUENCY = 12000000,
  parameter int SLICE_CYCLES  = CLK_FREQUENCY / 4
) (
  input  logic               clk,
  input  logic               rst,
  rgb_led_arbiter_if.slave   bus,
  output logic               RGB_R,
  output logic               RGB_G,
  output logic               RGB_B
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SLICE_W = $clog2(SLICE_CYCLES + 1);
  localparam logic [SLICE_W-1:0] SLICE_MAX = SLICE_W'(SLICE_CYCLES);

  arb_state_t         state;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   last_owner;
  logic [IDX_W-1:0]   next_owner;
  logic [SLICE_W-1:0] slice;
  logic [NUM_REQ-1:0] grant_q;
  color_t             shadow;
  logic               any_req;
  logic               others_req;
  logic               slice_done;

  function automatic color_t color_of(input logic [NUM_REQ*24-1:0] c,
                                      input logic [IDX_W-1:0] sel);
    return c[24*int'(sel) +: 24];
  endfunction

  assign any_req    = |bus.req;
  assign others_req = |(bus.req & ~(NUM_REQ'(1) << owner));
  assign slice_done = (slice >= SLICE_MAX);
  assign bus.grant  = grant_q;

  // Search upward from the previous owner; the lowest distance wins, so the loop runs far-to-near.
  always_comb begin
    next_owner = last_owner;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (bus.req[IDX_W'((int'(last_owner) + k) % NUM_REQ)]) begin
        next_owner = IDX_W'((int'(last_owner) + k) % NUM_REQ);
      end
    end
  end

  // Arbiter FSM with registered grant, shadow colour and slice counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= IDX_W'(NUM_REQ - 1);
      slice      <= '0;
      grant_q    <= '0;
      shadow     <= '0;
    end else begin
      case (state)
        IDLE, GAP: begin
          if (any_req) begin
            state   <= OWN;
            owner   <= next_owner;
            grant_q <= NUM_REQ'(1) << next_owner;
            slice   <= '0;
            shadow  <= color_of(bus.color, next_owner);
          end else begin
            state   <= IDLE;
            grant_q <= '0;
            shadow  <= '0;
          end
        end
        OWN: begin
          if (!bus.req[owner] || (slice_done && others_req)) begin
            state      <= GAP;
            grant_q    <= '0;
            shadow     <= '0;
            last_owner <= owner;
            slice      <= '0;
          end else begin
            shadow <= color_of(bus.color, owner);
            if (!slice_done) begin
              slice <= slice + SLICE_W'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_q <= '0;
          shadow  <= '0;
        end
      endcase
    end
  end

  rgb_pwm u_pwm (
    .clk    (clk),
    .rst    (rst),
    .shadow (shadow),
    .pwm_r  (RGB_R),
    .pwm_g  (RGB_G),
    .pwm_b  (RGB_B)
  );

endmodule

// File: doc/rgb_led_arbiter.md
# rgb_led_arbiter

Shares the board's single RGB LED PWM datapath among NUM_REQ requesters (status, heartbeat, hue effect, error, etc.). Round-robin arbitration with a per-grant time slice, break-before-make gaps between owners, and glitch-free colour updates applied only at PWM period boundaries. Sits between the effect generators and the RGB_R/RGB_G/RGB_B pins, replacing per-effect direct pin drive.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- CLK_FREQUENCY, 12000000, board clock in Hz
- SLICE_CYCLES, CLK_FREQUENCY/4, minimum ownership before preemption by a waiting requester

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester request, level
- color  in  NUM_REQ×24  per-requester colour, packed {r[7:0], g[7:0], b[7:0]}, requester i at bits [24i+23:24i]
- grant  out  NUM_REQ  one-hot-or-zero ownership
- RGB_R  out  1  red PWM
- RGB_G  out  1  green PWM
- RGB_B  out  1  blue PWM

## Operation
- States: IDLE, OWN, GAP.
- IDLE: grant=0, shadow duties 0. If any req high at a clock edge, choose first requester with req=1 searching upward (mod NUM_REQ) from last_owner+1; enter OWN, grant[owner]=1 at that edge.
- OWN: shadow duties = color[owner] every cycle (live tracking). slice counter increments, saturating at SLICE_CYCLES.
  - req[owner]=0 → GAP (release wins over every other condition).
  - slice == SLICE_CYCLES and any other req high → GAP (preemption).
  - slice == SLICE_CYCLES, no other req → stay in OWN, counter saturated.
- GAP: exactly one cycle, grant=0, shadow duties 0, last_owner=owner, slice cleared. Next edge: any req → arbitrate as in IDLE and enter OWN; none → IDLE.
- Handshake: requester holds req until done; grant drops within 1 cycle of req falling; a requester must not assume ownership until grant seen.
- PWM: 8-bit free-running pwm counter, wraps 255→0. Active duties load from shadow duties on the edge where pwm counter == 255. RGB_x registered = (pwm counter < active duty_x). Duty 0 → always low; duty 255 → high 255/256.
- Reset (any time, async): state IDLE, grant=0, last_owner=NUM_REQ-1 (requester 0 wins first), slice=0, pwm counter=0, shadow/active duties 0, RGB_R/G/B=0.

## Timing
- req rising sampled at edge E (IDLE) → grant visible after E (1 cycle latency).
- Ownership handover: req drop sampled at E → grant=0 after E (GAP), new grant after E+1.
- Colour to pin: shadow updates same edge as grant; pin reflects it from the first PWM period starting after the next pwm counter==255 edge, plus 1 register cycle; worst case 257 cycles.
- Never two grant bits high; never grant high in GAP/IDLE.
- Simultaneous requests: round-robin order only; no fixed priority beyond reset start point.
- slice width = $clog2(SLICE_CYCLES+1); compare is ≥ to tolerate saturation.

## Structure
- Package rgb_led_pkg: color_t packed struct {r,g,b} of 8 bits, PWM_BITS=8, arb_state_t enum {IDLE, OWN, GAP}.
- Sub-module rgb_pwm: pwm counter, shadow→active duty latch at period end, three comparators, registered outputs. Arbiter FSM, round-robin search and slice counter stay in rgb_led_arbiter.

## Test plan (NUM_REQ=4, SLICE_CYCLES=16)
- Reset then req=4'b0001, color0=FF0000 → grant=0001 one cycle later; after next period boundary RGB_R high 255 of 256 cycles, RGB_G/RGB_B stay 0.
- req=4'b1111 held from reset → grants 0001,0010,0100,1000,0001 in order, each 17 OWN cycles (slice reaches 16) separated by exactly one all-zero grant cycle.
- Owner 0 alone for 100 cycles → grant stays 0001, no GAP; assert req1 at cycle 100 → grant 0000 next cycle, 0010 the cycle after.
- Owner changes color0 000000→808080 at pwm counter=10 → pins unchanged until counter wraps; then each output high exactly 128 of 256 cycles.
- Owner drops req on the same edge slice hits 16 with req2 pending → single GAP cycle, then grant=0100.
- Assert rst mid-OWN with RGB_R high → grant, RGB_R/G/B go 0 immediately without a clock; after release, req=4'b0110 → requester 1 granted first.
